// File: rtl/seg_scan_if.sv
// Multiplexed 7-segment scanner bus: hex/dp/enable requests in, digit select
// and active-low segment drive out.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 6
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   en_mask;
    logic                    load;
    logic                    lz_en;
    logic [2:0]              sel;
    logic [7:0]              seg;
    logic                    frame_done;

    modport master (
        output data_in, dp_in, en_mask, load, lz_en,
        input  sel, seg, frame_done
    );

    modport slave (
        input  data_in, dp_in, en_mask, load, lz_en,
        output sel, seg, frame_done
    );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed 7-segment display scanner with per-slot anti-ghosting
// blanking, leading-zero suppression and shadowed digit data.
module seg_scan #(
    parameter int NUM_DIGITS = 6,
    parameter int DIV_CNT    = 50000,
    parameter int BLANK_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    seg_scan_if.slave   bus
);
    localparam int CW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam int BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

    logic [CW-1:0]           div_cnt;
    logic [BW-1:0]           blank_cnt;
    logic [4*NUM_DIGITS-1:0] data_shadow;
    logic [NUM_DIGITS-1:0]   dp_shadow;
    logic                    tick;
    logic [NUM_DIGITS-1:0]   zero_above;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    cur_lz;
    logic [7:0]              pattern;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick = (div_cnt == CW'(DIV_CNT - 1));

    // zero_above[i] is set when nibble i and every higher nibble are zero.
    always_comb begin
        logic acc;
        acc        = 1'b1;
        zero_above = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc           = acc & (data_shadow[4*i +: 4] == 4'h0);
            zero_above[i] = acc;
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.sel == 3'(i)) begin
                cur_nib = data_shadow[4*i +: 4];
                cur_dp  = dp_shadow[i];
                cur_en  = bus.en_mask[i];
                cur_lz  = bus.lz_en && (i != 0) && zero_above[i];
            end
        end
    end

    // Masked digits go fully dark, decimal point included.
    always_comb begin
        pattern = 8'hFF;
        if (cur_en) begin
            pattern = {~cur_dp, cur_lz ? 7'h7F : seg_decode(cur_nib)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt        <= '0;
            blank_cnt      <= '0;
            bus.sel        <= 3'd0;
            bus.frame_done <= 1'b0;
            bus.seg        <= 8'hFF;
            data_shadow    <= '0;
            dp_shadow      <= '0;
        end else begin
            if (bus.load) begin
                data_shadow <= bus.data_in;
                dp_shadow   <= bus.dp_in;
            end
            div_cnt        <= tick ? '0 : div_cnt + CW'(1);
            bus.frame_done <= 1'b0;
            if (tick) begin
                if (bus.sel == 3'(NUM_DIGITS - 1)) begin
                    bus.sel        <= 3'd0;
                    bus.frame_done <= 1'b1;
                end else begin
                    bus.sel <= bus.sel + 3'd1;
                end
                bus.seg   <= 8'hFF;
                blank_cnt <= BW'(BLANK_CYC);
            end else if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - BW'(1);
                bus.seg   <= 8'hFF;
            end else begin
                bus.seg <= pattern;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: 4-digit main instance plus 1- and 8-digit
// instances sharing clock and reset for wrap/frame checks.
module tb_seg_scan;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    seg_scan_if #(.NUM_DIGITS(4)) bus4 ();
    seg_scan_if #(.NUM_DIGITS(1)) bus1 ();
    seg_scan_if #(.NUM_DIGITS(8)) bus8 ();

    seg_scan #(.NUM_DIGITS(4), .DIV_CNT(8), .BLANK_CYC(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
    );
    seg_scan #(.NUM_DIGITS(1), .DIV_CNT(8), .BLANK_CYC(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );
    seg_scan #(.NUM_DIGITS(8), .DIV_CNT(8), .BLANK_CYC(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sync to the first sample after sel changes to s; the slot starts blanked.
    task automatic wait_slot(input logic [2:0] s);
        logic [2:0] prev;
        logic       found;
        prev  = bus4.sel;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus4.sel == s && prev != s) begin
                found = 1'b1;
                break;
            end
            prev = bus4.sel;
        end
        check($sformatf("slot%0d_reached", s), 32'(found), 32'h1);
        check($sformatf("slot%0d_blank", s), 32'(bus4.seg), 32'hFF);
    endtask

    task automatic slot_pattern(input logic [2:0] s, input logic [7:0] exp);
        wait_slot(s);
        step(3);
        check($sformatf("slot%0d_pattern", s), 32'(bus4.seg), 32'(exp));
    endtask

    initial begin
        int fd1, fd4, fd8;
        logic [2:0] max1, max4, max8;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus4.data_in = '0; bus4.dp_in = '0; bus4.en_mask = 4'hF;  bus4.load = 1'b0; bus4.lz_en = 1'b0;
        bus1.data_in = '0; bus1.dp_in = '0; bus1.en_mask = 1'b1;  bus1.load = 1'b0; bus1.lz_en = 1'b0;
        bus8.data_in = '0; bus8.dp_in = '0; bus8.en_mask = 8'hFF; bus8.load = 1'b0; bus8.lz_en = 1'b0;

        step(3);
        check("reset_seg", 32'(bus4.seg), 32'hFF);
        check("reset_sel", 32'(bus4.sel), 32'h0);
        check("reset_fd", 32'(bus4.frame_done), 32'h0);
        rst_n = 1'b1;

        step(1);
        check("first_edge_seg", 32'(bus4.seg), 32'hC0);
        check("first_edge_sel", 32'(bus4.sel), 32'h0);
        step(6);
        check("pre_tick_sel", 32'(bus4.sel), 32'h0);
        check("pre_tick_seg", 32'(bus4.seg), 32'hC0);
        step(1);
        check("tick1_sel", 32'(bus4.sel), 32'h1);
        check("tick1_blank0", 32'(bus4.seg), 32'hFF);
        step(1);
        check("tick1_blank1", 32'(bus4.seg), 32'hFF);
        step(1);
        check("tick1_blank2", 32'(bus4.seg), 32'hFF);
        step(1);
        check("tick1_pattern", 32'(bus4.seg), 32'hC0);
        step(20);
        check("slot3_sel", 32'(bus4.sel), 32'h3);
        check("slot3_fd_low", 32'(bus4.frame_done), 32'h0);
        step(1);
        check("wrap_sel", 32'(bus4.sel), 32'h0);
        check("wrap_fd", 32'(bus4.frame_done), 32'h1);
        step(1);
        check("wrap_fd_clear", 32'(bus4.frame_done), 32'h0);
        step(31);
        check("frame2_fd", 32'(bus4.frame_done), 32'h1);

        bus4.data_in = 16'h0A5F;
        bus4.dp_in   = 4'b0010;
        bus4.load    = 1'b1;
        step(1);
        bus4.load    = 1'b0;
        slot_pattern(3'd0, 8'h8E);
        slot_pattern(3'd1, 8'h12);
        slot_pattern(3'd2, 8'h88);
        slot_pattern(3'd3, 8'hC0);

        bus4.lz_en   = 1'b1;
        bus4.data_in = 16'h000F;
        bus4.load    = 1'b1;
        step(3);
        bus4.load    = 1'b0;
        slot_pattern(3'd0, 8'h8E);
        bus4.data_in = 16'h0001;
        bus4.load    = 1'b1;
        step(1);
        bus4.load    = 1'b0;
        check("load_same_edge", 32'(bus4.seg), 32'h8E);
        step(1);
        check("load_next_edge", 32'(bus4.seg), 32'hF9);
        slot_pattern(3'd1, 8'h7F);
        slot_pattern(3'd2, 8'hFF);
        slot_pattern(3'd3, 8'hFF);

        bus4.lz_en   = 1'b0;
        bus4.en_mask = 4'b1011;
        bus4.data_in = 16'h0A5F;
        bus4.load    = 1'b1;
        step(1);
        bus4.load    = 1'b0;
        slot_pattern(3'd0, 8'h8E);
        slot_pattern(3'd1, 8'h12);
        slot_pattern(3'd2, 8'hFF);
        step(4);
        check("masked_slot_end", 32'(bus4.seg), 32'hFF);
        slot_pattern(3'd3, 8'hC0);
        bus4.en_mask = 4'hF;

        wait_slot(3'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sel", 32'(bus4.sel), 32'h0);
        check("async_rst_seg", 32'(bus4.seg), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        fd1 = 0; fd4 = 0; fd8 = 0;
        max1 = '0; max4 = '0; max8 = '0;
        for (int k = 1; k <= 128; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("post_rst_seg4", 32'(bus4.seg), 32'hC0);
                check("post_rst_seg1", 32'(bus1.seg), 32'hC0);
                check("post_rst_seg8", 32'(bus8.seg), 32'hC0);
            end
            fd1 += int'(bus1.frame_done);
            fd4 += int'(bus4.frame_done);
            fd8 += int'(bus8.frame_done);
            if (bus1.sel > max1) max1 = bus1.sel;
            if (bus4.sel > max4) max4 = bus4.sel;
            if (bus8.sel > max8) max8 = bus8.sel;
        end
        check("fd_count_1digit", 32'(fd1), 32'd16);
        check("fd_count_4digit", 32'(fd4), 32'd4);
        check("fd_count_8digit", 32'(fd8), 32'd2);
        check("sel_max_1digit", 32'(max1), 32'd0);
        check("sel_max_4digit", 32'(max4), 32'd3);
        check("sel_max_8digit", 32'(max8), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
